// File: rtl/fp_add_seq.sv
// Multi-cycle single-precision adder: capture/select, align, add, normalize, hold result.
// Define FP_ADD_BARREL_EN to replace the serial aligner with a one-cycle barrel shift.
module fp_add_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        ovf,
  output logic        unf
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // in_ready is high only in IDLE, out_valid only in DONE, and DONE holds until out_ready.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ALIGN = 3'd1,
    ADD   = 3'd2,
    NORM  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t      state;
  logic        big_sign;
  logic        eff_sub;
  logic [8:0]  exp_r;
  logic [23:0] big_man;
  logic [23:0] small_man;
  logic [4:0]  cnt;
  logic [24:0] sum;
  logic        special;
  logic [31:0] special_val;

  // Operand unpack and larger-operand selection, used on the accept cycle.
  logic [7:0]  a_exp, b_exp, big_exp_c, small_exp_c;
  logic [23:0] a_man, b_man, big_man_c, small_man_c;
  logic        a_big, big_sign_c, small_sign_c;
  logic [8:0]  diff;
  logic [4:0]  shamt;

  always_comb begin
    a_exp        = a[30:23];
    b_exp        = b[30:23];
    a_man        = (a_exp != 8'd0) ? {1'b1, a[22:0]} : 24'd0;
    b_man        = (b_exp != 8'd0) ? {1'b1, b[22:0]} : 24'd0;
    a_big        = (a_exp > b_exp) || ((a_exp == b_exp) && (a_man >= b_man));
    big_exp_c    = a_big ? a_exp : b_exp;
    small_exp_c  = a_big ? b_exp : a_exp;
    big_man_c    = a_big ? a_man : b_man;
    small_man_c  = a_big ? b_man : a_man;
    big_sign_c   = a_big ? a[31] : b[31];
    small_sign_c = a_big ? b[31] : a[31];
    diff         = {1'b0, big_exp_c} - {1'b0, small_exp_c};
    shamt        = (diff > 9'd25) ? 5'd25 : diff[4:0];
  end

  // One normalization decision per NORM cycle; the priority order matters.
  logic        norm_done, norm_ovf, norm_unf;
  logic [31:0] norm_res;

  always_comb begin
    norm_done = 1'b0;
    norm_ovf  = 1'b0;
    norm_unf  = 1'b0;
    norm_res  = 32'd0;
    if (sum == 25'd0) begin
      norm_done = 1'b1;
    end else if (sum[24]) begin
      norm_done = 1'b0;
    end else if (exp_r >= 9'd255) begin
      norm_done = 1'b1;
      norm_ovf  = 1'b1;
      norm_res  = {big_sign, 8'hFF, 23'd0};
    end else if (!sum[23] && (exp_r > 9'd1)) begin
      norm_done = 1'b0;
    end else if (!sum[23]) begin
      norm_done = 1'b1;
      norm_unf  = 1'b1;
      norm_res  = {big_sign, 31'd0};
    end else begin
      norm_done = 1'b1;
      norm_res  = {big_sign, exp_r[7:0], sum[22:0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      result      <= 32'd0;
      ovf         <= 1'b0;
      unf         <= 1'b0;
      big_sign    <= 1'b0;
      eff_sub     <= 1'b0;
      exp_r       <= 9'd0;
      big_man     <= 24'd0;
      small_man   <= 24'd0;
      cnt         <= 5'd0;
      sum         <= 25'd0;
      special     <= 1'b0;
      special_val <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            big_sign    <= big_sign_c;
            eff_sub     <= big_sign_c ^ small_sign_c;
            exp_r       <= {1'b0, big_exp_c};
            big_man     <= big_man_c;
            small_man   <= small_man_c;
            cnt         <= shamt;
            special     <= (a_exp == 8'hFF) || (b_exp == 8'hFF);
            special_val <= (a_exp == 8'hFF) ? a : b;
            ovf         <= 1'b0;
            unf         <= 1'b0;
            in_ready    <= 1'b0;
            state       <= ALIGN;
          end
        end
        ALIGN: begin
`ifdef FP_ADD_BARREL_EN
          small_man <= small_man >> cnt;
          cnt       <= 5'd0;
          state     <= ADD;
`else
          if (cnt != 5'd0) begin
            small_man <= small_man >> 1;
            cnt       <= cnt - 5'd1;
          end
          // A zero count still spends this one cycle here.
          if (cnt <= 5'd1) state <= ADD;
`endif
        end
        ADD: begin
          sum   <= eff_sub ? ({1'b0, big_man} - {1'b0, small_man})
                           : ({1'b0, big_man} + {1'b0, small_man});
          state <= NORM;
        end
        NORM: begin
          if (norm_done) begin
            result    <= special ? special_val : norm_res;
            ovf       <= special ? 1'b0 : norm_ovf;
            unf       <= special ? 1'b0 : norm_unf;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (sum[24]) begin
            sum   <= sum >> 1;
            exp_r <= exp_r + 9'd1;
          end else begin
            sum   <= sum << 1;
            exp_r <= exp_r - 9'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
